// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS controller: FSM states,
// opcode/funct encodings, ALU control codes and ALU-op selectors.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StRex,
    StRwb, StBeq, StBne, StIex, StIwb, StJmp, StTrap
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;
  localparam logic [1:0] AluOpImm   = 2'b11;

  function automatic logic is_rfunct(input logic [5:0] f);
    return (f == FnAdd) || (f == FnSub) || (f == FnAnd) || (f == FnOr) || (f == FnSlt);
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's ALU-op selector plus op/funct to an ALU control
// code; immediate ops also select zero-extension for andi/ori.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       imm_zext
);

  always_comb begin
    alucontrol = AluAdd;
    imm_zext   = 1'b0;
    case (aluop)
      AluOpSub: alucontrol = AluSub;
      AluOpFunct: begin
        case (funct)
          FnSub:   alucontrol = AluSub;
          FnAnd:   alucontrol = AluAnd;
          FnOr:    alucontrol = AluOr;
          FnSlt:   alucontrol = AluSlt;
          default: alucontrol = AluAdd;
        endcase
      end
      AluOpImm: begin
        case (op)
          OpAndi: begin
            alucontrol = AluAnd;
            imm_zext   = 1'b1;
          end
          OpOri: begin
            alucontrol = AluOr;
            imm_zext   = 1'b1;
          end
          OpSlti:  alucontrol = AluSlt;
          default: alucontrol = AluAdd;
        endcase
      end
      default: alucontrol = AluAdd;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: main FSM, output decode, ALU decode and a
// retired-instruction counter, with memory wait states and an illegal-op trap.
module mc_controller
  import mc_pkg::*;
#(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter bit          EXT_ISA     = 1'b1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             branch,
  output logic             branch_ne,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic             imm_zext,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       aluop;
  logic             rdy;

  assign rdy         = mem_ready | ~MEM_WAIT_EN;
  assign instr_count = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      // An instruction retires whenever the FSM re-enters FETCH.
      if (state_d == StFetch && state_q != StFetch) count_q <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (rdy) state_d = StDecode;
      StDecode: begin
        if (op == OpRtype && is_rfunct(funct)) begin
          state_d = StRex;
        end else begin
          case (op)
            OpLw, OpSw:            state_d = StMemAdr;
            OpBeq:                 state_d = StBeq;
            OpAddi:                state_d = StIex;
            OpJ:                   state_d = StJmp;
            OpAndi, OpOri, OpSlti: state_d = EXT_ISA ? StIex : StTrap;
            OpBne:                 state_d = EXT_ISA ? StBne : StTrap;
            default:               state_d = StTrap;
          endcase
        end
      end
      StMemAdr: state_d = (op == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (rdy) state_d = StMemWb;
      StMemWr:  if (rdy) state_d = StFetch;
      StRex:    state_d = StRwb;
      StIex:    state_d = StIwb;
      StTrap:   state_d = StTrap;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    pcwrite   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    iord      = 1'b0;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    aluop     = AluOpAdd;
    illegal   = 1'b0;
    case (state_q)
      StFetch: begin
        alusrcb = 2'b01;
        irwrite = rdy;
        pcwrite = rdy;
      end
      StDecode: alusrcb = 2'b11;
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: iord = 1'b1;
      StMemWb: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      StMemWr: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      StRex: begin
        alusrca = 1'b1;
        aluop   = AluOpFunct;
      end
      StRwb: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      StBeq, StBne: begin
        alusrca   = 1'b1;
        aluop     = AluOpSub;
        pcsrc     = 2'b01;
        branch    = (state_q == StBeq);
        branch_ne = (state_q == StBne);
      end
      StIex: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = AluOpImm;
      end
      StIwb: regwrite = 1'b1;
      StJmp: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      StTrap:  illegal = 1'b1;
      default: ;
    endcase
  end

  mc_aludec u_aludec (
    .aluop      (aluop),
    .op         (op),
    .funct      (funct),
    .alucontrol (alucontrol),
    .imm_zext   (imm_zext)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus pushes the hand-derived control
// vector expected for each cycle; a negedge monitor pops and compares.
module tb_mc_controller;

  typedef struct packed {
    logic       pcwrite, branch, branch_ne, memwrite, irwrite, regwrite;
    logic       alusrca, iord, memtoreg, regdst, imm_zext;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
  } ctl_t;

  typedef struct {
    string       tag;
    ctl_t        ctl;
    logic [31:0] cnt;
    bit          alt;
  } exp_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, JOP = 6'b000010, RT = 6'b000000;

  localparam ctl_t F_RDY  = '{pcwrite: 1'b1, irwrite: 1'b1, alusrcb: 2'b01,
                              alucontrol: 3'b010, default: '0};
  localparam ctl_t F_NR   = '{alusrcb: 2'b01, alucontrol: 3'b010, default: '0};
  localparam ctl_t DEC    = '{alusrcb: 2'b11, alucontrol: 3'b010, default: '0};
  localparam ctl_t MADR   = '{alusrca: 1'b1, alusrcb: 2'b10, alucontrol: 3'b010, default: '0};
  localparam ctl_t MRD    = '{iord: 1'b1, alucontrol: 3'b010, default: '0};
  localparam ctl_t MWB    = '{regwrite: 1'b1, memtoreg: 1'b1, alucontrol: 3'b010, default: '0};
  localparam ctl_t MWR    = '{iord: 1'b1, memwrite: 1'b1, alucontrol: 3'b010, default: '0};
  localparam ctl_t REX_OR = '{alusrca: 1'b1, alucontrol: 3'b001, default: '0};
  localparam ctl_t RWB    = '{regwrite: 1'b1, regdst: 1'b1, alucontrol: 3'b010, default: '0};
  localparam ctl_t BQ     = '{alusrca: 1'b1, alucontrol: 3'b110, pcsrc: 2'b01, branch: 1'b1,
                              default: '0};
  localparam ctl_t BN     = '{alusrca: 1'b1, alucontrol: 3'b110, pcsrc: 2'b01,
                              branch_ne: 1'b1, default: '0};
  localparam ctl_t IEX_AD = '{alusrca: 1'b1, alusrcb: 2'b10, alucontrol: 3'b010, default: '0};
  localparam ctl_t IEX_OR = '{alusrca: 1'b1, alusrcb: 2'b10, alucontrol: 3'b001,
                              imm_zext: 1'b1, default: '0};
  localparam ctl_t IWB    = '{regwrite: 1'b1, alucontrol: 3'b010, default: '0};
  localparam ctl_t JMP    = '{pcwrite: 1'b1, pcsrc: 2'b10, alucontrol: 3'b010, default: '0};
  localparam ctl_t TRAP   = '{illegal: 1'b1, alucontrol: 3'b010, default: '0};

  logic        clk = 1'b0, reset = 1'b1, mem_ready = 1'b1;
  logic [5:0]  op = '0, funct = '0;

  logic        pcwrite0, branch0, branch_ne0, memwrite0, irwrite0, regwrite0, alusrca0;
  logic        iord0, memtoreg0, regdst0, imm_zext0, illegal0;
  logic [1:0]  alusrcb0, pcsrc0;
  logic [2:0]  alucontrol0;
  logic [31:0] cnt0;
  logic        pcwrite1, branch1, branch_ne1, memwrite1, irwrite1, regwrite1, alusrca1;
  logic        iord1, memtoreg1, regdst1, imm_zext1, illegal1;
  logic [1:0]  alusrcb1, pcsrc1;
  logic [2:0]  alucontrol1;
  logic [31:0] cnt1;
  ctl_t        ctl0, ctl1;

  int checks = 0, failures = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  mc_controller u_dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
    .pcwrite(pcwrite0), .branch(branch0), .branch_ne(branch_ne0), .memwrite(memwrite0),
    .irwrite(irwrite0), .regwrite(regwrite0), .alusrca(alusrca0), .iord(iord0),
    .memtoreg(memtoreg0), .regdst(regdst0), .imm_zext(imm_zext0), .alusrcb(alusrcb0),
    .pcsrc(pcsrc0), .alucontrol(alucontrol0), .illegal(illegal0), .instr_count(cnt0)
  );

  // Base-ISA instance: extended opcodes must trap here.
  mc_controller #(.EXT_ISA(1'b0)) u_dut_base (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
    .pcwrite(pcwrite1), .branch(branch1), .branch_ne(branch_ne1), .memwrite(memwrite1),
    .irwrite(irwrite1), .regwrite(regwrite1), .alusrca(alusrca1), .iord(iord1),
    .memtoreg(memtoreg1), .regdst(regdst1), .imm_zext(imm_zext1), .alusrcb(alusrcb1),
    .pcsrc(pcsrc1), .alucontrol(alucontrol1), .illegal(illegal1), .instr_count(cnt1)
  );

  assign ctl0 = {pcwrite0, branch0, branch_ne0, memwrite0, irwrite0, regwrite0, alusrca0,
                 iord0, memtoreg0, regdst0, imm_zext0, alusrcb0, pcsrc0, alucontrol0, illegal0};
  assign ctl1 = {pcwrite1, branch1, branch_ne1, memwrite1, irwrite1, regwrite1, alusrca1,
                 iord1, memtoreg1, regdst1, imm_zext1, alusrcb1, pcsrc1, alucontrol1, illegal1};

  exp_t        m_e;
  ctl_t        m_ctl;
  logic [31:0] m_cnt;

  always @(negedge clk) begin
    if (q.size() != 0) begin
      m_e   = q.pop_front();
      m_ctl = m_e.alt ? ctl1 : ctl0;
      m_cnt = m_e.alt ? cnt1 : cnt0;
      checks++;
      if (m_ctl !== m_e.ctl) begin
        failures++;
        $display("FAIL %s ctl got=%b exp=%b", m_e.tag, m_ctl, m_e.ctl);
      end
      checks++;
      if (m_cnt !== m_e.cnt) begin
        failures++;
        $display("FAIL %s instr_count got=%0d exp=%0d", m_e.tag, m_cnt, m_e.cnt);
      end
    end
  end

  task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f, input logic rdy,
                     input string tag, input ctl_t c, input logic [31:0] n, input bit alt = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = r;
    op        = o;
    funct     = f;
    mem_ready = rdy;
    e.tag = tag;
    e.ctl = c;
    e.cnt = n;
    e.alt = alt;
    q.push_back(e);
  endtask

  initial begin
    cyc(1, LW, 6'd0, 1, "reset", F_RDY, 0);
    // lw: five cycles, retires once
    cyc(0, LW, 6'd0, 1, "lw_fetch", F_RDY, 0);
    cyc(0, LW, 6'd0, 1, "lw_decode", DEC, 0);
    cyc(0, LW, 6'd0, 1, "lw_memadr", MADR, 0);
    cyc(0, LW, 6'd0, 1, "lw_memrd", MRD, 0);
    cyc(0, LW, 6'd0, 1, "lw_memwb", MWB, 0);
    // sw with wait states in FETCH and MEMWR
    for (int i = 0; i < 3; i++) cyc(0, SW, 6'd0, 0, "sw_fetch_stall", F_NR, 1);
    cyc(0, SW, 6'd0, 1, "sw_fetch", F_RDY, 1);
    cyc(0, SW, 6'd0, 1, "sw_decode", DEC, 1);
    cyc(0, SW, 6'd0, 1, "sw_memadr", MADR, 1);
    for (int i = 0; i < 3; i++) cyc(0, SW, 6'd0, 0, "sw_memwr_wait", MWR, 1);
    cyc(0, SW, 6'd0, 1, "sw_memwr_done", MWR, 1);
    cyc(0, BEQ, 6'd0, 1, "beq_fetch", F_RDY, 2);
    cyc(0, BEQ, 6'd0, 1, "beq_decode", DEC, 2);
    cyc(0, BEQ, 6'd0, 1, "beq_exec", BQ, 2);
    cyc(0, BNE, 6'd0, 1, "bne_fetch", F_RDY, 3);
    cyc(0, BNE, 6'd0, 1, "bne_decode", DEC, 3);
    cyc(0, BNE, 6'd0, 1, "bne_exec", BN, 3);
    cyc(0, RT, 6'b100101, 1, "or_fetch", F_RDY, 4);
    cyc(0, RT, 6'b100101, 1, "or_decode", DEC, 4);
    cyc(0, RT, 6'b100101, 1, "or_rex", REX_OR, 4);
    cyc(0, RT, 6'b100101, 1, "or_rwb", RWB, 4);
    cyc(0, ADDI, 6'd0, 1, "addi_fetch", F_RDY, 5);
    cyc(0, ADDI, 6'd0, 1, "addi_decode", DEC, 5);
    cyc(0, ADDI, 6'd0, 1, "addi_iex", IEX_AD, 5);
    cyc(0, ADDI, 6'd0, 1, "addi_iwb", IWB, 5);
    cyc(0, ORI, 6'd0, 1, "ori_fetch", F_RDY, 6);
    cyc(0, ORI, 6'd0, 1, "ori_decode", DEC, 6);
    cyc(0, ORI, 6'd0, 1, "ori_iex", IEX_OR, 6);
    cyc(0, ORI, 6'd0, 1, "ori_iwb", IWB, 6);
    cyc(0, JOP, 6'd0, 1, "j_fetch", F_RDY, 7);
    cyc(0, JOP, 6'd0, 1, "j_decode", DEC, 7);
    cyc(0, JOP, 6'd0, 1, "j_jmp", JMP, 7);
    // R-type with an unsupported funct traps
    cyc(0, RT, 6'd0, 1, "rbad_fetch", F_RDY, 8);
    cyc(0, RT, 6'd0, 1, "rbad_decode", DEC, 8);
    for (int i = 0; i < 3; i++) cyc(0, RT, 6'd0, 1, "rbad_trap", TRAP, 8);
    cyc(1, RT, 6'd0, 1, "trap_reset", F_RDY, 0);
    // reset while memwrite is asserted
    cyc(0, SW, 6'd0, 1, "swr_fetch", F_RDY, 0);
    cyc(0, SW, 6'd0, 1, "swr_decode", DEC, 0);
    cyc(0, SW, 6'd0, 1, "swr_memadr", MADR, 0);
    cyc(0, SW, 6'd0, 0, "swr_memwr", MWR, 0);
    cyc(1, SW, 6'd0, 0, "swr_async_reset", F_NR, 0);
    // ori on the base-ISA instance
    cyc(0, ORI, 6'd0, 1, "base_ori_fetch", F_RDY, 0, 1'b1);
    cyc(0, ORI, 6'd0, 1, "base_ori_decode", DEC, 0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(0, ORI, 6'd0, 1, "base_ori_trap", TRAP, 0, 1'b1);
    cyc(1, ORI, 6'd0, 1, "base_reset", F_RDY, 0, 1'b1);
    cyc(0, ORI, 6'd0, 1, "base_after_reset", F_RDY, 0, 1'b1);

    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
